mult_14x14: RTL and testbench

//   Parameterised integer multiplier with product truncation to RES_W bits.

---
 rtl/fft_pkg.sv | 9 +
 rtl/mult_pipe_reg.sv | 33 +++
 rtl/mult_14x14.sv | 88 ++++++++
 tb/tb_mult_14x14.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared widths for the FFT peak-bin datapath: RAM word halves and the
// magnitude metric formed from them.
package fft_pkg;

    localparam int FFT_HALF_W = 14;
    localparam int MAG_W      = 24;
    localparam int FFT_PROD_W = 2 * FFT_HALF_W;

endpackage : fft_pkg

// File: rtl/mult_pipe_reg.sv
// One product pipeline stage: a W-bit register with asynchronous active-low
// clear and a clock enable that holds the stage when low.
module mult_pipe_reg #(
    parameter int W = 25
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (ena) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule : mult_pipe_reg

// File: rtl/mult_14x14.sv
// Integer multiplier with wrapping truncation to RES_W bits, an overflow flag
// and an optional LATENCY-stage output pipeline (0 = purely combinational).
module mult_14x14
    import fft_pkg::*;
#(
    parameter int A_W     = FFT_HALF_W,
    parameter int B_W     = FFT_HALF_W,
    parameter int RES_W   = MAG_W,
    parameter int SIGNED  = 0,
    parameter int LATENCY = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic [A_W-1:0]   dataa_0,
    input  logic [B_W-1:0]   datab_0,
    output logic [RES_W-1:0] result,
    output logic             ovf
);

    localparam int P_W = A_W + B_W;

    logic [P_W-1:0]   a_ext;
    logic [P_W-1:0]   b_ext;
    logic [P_W-1:0]   prod;
    logic [RES_W-1:0] res_c;
    logic             ovf_c;

    // The low P_W bits of the product are identical for signed and unsigned
    // multiplication once both operands are extended to P_W bits.
    always_comb begin
        if (SIGNED != 0) begin
            a_ext = {{B_W{dataa_0[A_W-1]}}, dataa_0};
            b_ext = {{A_W{datab_0[B_W-1]}}, datab_0};
        end else begin
            a_ext = {{B_W{1'b0}}, dataa_0};
            b_ext = {{A_W{1'b0}}, datab_0};
        end
        prod = a_ext * b_ext;
    end

    generate
        if (RES_W > P_W) begin : g_extend
            logic fill_bit;
            assign fill_bit = (SIGNED != 0) ? prod[P_W-1] : 1'b0;
            assign res_c    = {{(RES_W-P_W){fill_bit}}, prod};
            assign ovf_c    = 1'b0;
        end else if (RES_W == P_W) begin : g_exact
            assign res_c = prod;
            assign ovf_c = 1'b0;
        end else begin : g_trunc
            assign res_c = prod[RES_W-1:0];
            if (SIGNED != 0) begin : g_signed_ovf
                // Fits only if the kept sign bit matches every discarded bit.
                logic [P_W-RES_W:0] top_bits;
                assign top_bits = prod[P_W-1:RES_W-1];
                assign ovf_c    = !((&top_bits) || !(|top_bits));
            end else begin : g_unsigned_ovf
                assign ovf_c = |prod[P_W-1:RES_W];
            end
        end
    endgenerate

    logic [RES_W:0] pipe [LATENCY+1];

    assign pipe[0] = {res_c, ovf_c};

    generate
        for (genvar i = 0; i < LATENCY; i++) begin : g_stage
            mult_pipe_reg #(
                .W (RES_W + 1)
            ) u_stage (
                .clk   (clk),
                .rst_n (reset),
                .ena   (ena),
                .d     (pipe[i]),
                .q     (pipe[i+1])
            );
        end
        if (LATENCY == 0) begin : g_comb_only
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clk, reset, ena};
        end
    endgenerate

    assign {result, ovf} = pipe[LATENCY];

endmodule : mult_14x14

// File: tb/tb_mult_14x14.sv
// Bench for mult_14x14: combinational unsigned/signed/extended variants and a
// two-stage pipelined variant checked against an arithmetic reference model.
module tb_mult_14x14;

    logic        clk;
    logic        reset_n;
    logic        ena;

    logic [13:0] a_u, b_u, a_s, b_s, a_l, b_l;
    logic [23:0] r_u, r_s, r_l;
    logic [31:0] r_w;
    logic        o_u, o_s, o_l, o_w;

    int n_chk;
    int n_err;

    logic [24:0] exp_q [$];

    mult_14x14 u_dut_u (
        .clk (clk), .reset (reset_n), .ena (ena),
        .dataa_0 (a_u), .datab_0 (b_u), .result (r_u), .ovf (o_u)
    );

    mult_14x14 #(.SIGNED(1)) u_dut_s (
        .clk (clk), .reset (reset_n), .ena (ena),
        .dataa_0 (a_s), .datab_0 (b_s), .result (r_s), .ovf (o_s)
    );

    mult_14x14 #(.RES_W(32), .SIGNED(1)) u_dut_w (
        .clk (clk), .reset (reset_n), .ena (ena),
        .dataa_0 (a_s), .datab_0 (b_s), .result (r_w), .ovf (o_w)
    );

    mult_14x14 #(.LATENCY(2)) u_dut_l (
        .clk (clk), .reset (reset_n), .ena (ena),
        .dataa_0 (a_l), .datab_0 (b_l), .result (r_l), .ovf (o_l)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference: true integer product, then wrap and range-check in RW bits.
    function automatic void model(input int a_raw, input int b_raw, input bit sgn,
                                  input int rw, output logic [31:0] res,
                                  output logic ovf_m);
        longint a;
        longint b;
        longint p;
        longint lim;
        a = a_raw;
        b = b_raw;
        if (sgn && a_raw >= 8192) a = a_raw - 16384;
        if (sgn && b_raw >= 8192) b = b_raw - 16384;
        p   = a * b;
        lim = longint'(1) << rw;
        if (sgn) ovf_m = (p < -(lim / 2)) || (p >= lim / 2);
        else     ovf_m = (p >= lim);
        res = 32'(p & (lim - 1));
    endfunction

    task automatic step(input logic [13:0] a, input logic [13:0] b, input logic en);
        logic [31:0] m_res;
        logic        m_ovf;
        a_l = a;
        b_l = b;
        ena = en;
        @(posedge clk);
        if (en) begin
            model(int'(a), int'(b), 1'b0, 24, m_res, m_ovf);
            void'(exp_q.pop_front());
            exp_q.push_back({m_res[23:0], m_ovf});
        end
        @(negedge clk);
        n_chk++;
        if ({r_l, o_l} !== exp_q[0]) begin
            n_err++;
            $display("FAIL pipe_step: got res=%h ovf=%b, expected res=%h ovf=%b",
                     r_l, o_l, exp_q[0][24:1], exp_q[0][0]);
        end
    endtask

    task automatic test_reset();
        logic [31:0] m_res;
        logic        m_ovf;
        reset_n = 1'b0;
        ena     = 1'b1;
        a_l = 14'd1234; b_l = 14'd4321;
        a_u = 14'd300;  b_u = 14'd7;
        #15;
        n_chk++;
        if (r_l !== 24'd0 || o_l !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pipe: got res=%h ovf=%b, expected res=000000 ovf=0", r_l, o_l);
        end
        model(300, 7, 1'b0, 24, m_res, m_ovf);
        n_chk++;
        if (r_u !== m_res[23:0] || o_u !== m_ovf) begin
            n_err++;
            $display("FAIL reset_comb: got res=%h ovf=%b, expected res=%h ovf=%b",
                     r_u, o_u, m_res[23:0], m_ovf);
        end
        a_l = '0;
        b_l = '0;
        exp_q = '{25'd0, 25'd0};
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_unsigned_directed();
        logic [13:0] ta [4] = '{14'd100, 14'd4095, 14'd4096, 14'd16383};
        logic [13:0] tb [4] = '{14'd200, 14'd4096, 14'd4096, 14'd16383};
        logic [23:0] tr [4] = '{24'h004E20, 24'hFFF000, 24'h000000, 24'hFF8001};
        logic        to [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            a_u = ta[i];
            b_u = tb[i];
            #1;
            n_chk++;
            if (r_u !== tr[i] || o_u !== to[i]) begin
                n_err++;
                $display("FAIL unsigned_dir%0d: got res=%h ovf=%b, expected res=%h ovf=%b",
                         i, r_u, o_u, tr[i], to[i]);
            end
        end
    endtask

    task automatic test_signed_directed();
        logic [13:0] ta [3] = '{14'h2000, 14'h3FFF, 14'h2000};
        logic [13:0] tb [3] = '{14'h0001, 14'h3FFF, 14'h2000};
        logic [23:0] tr [3] = '{24'hFFE000, 24'h000001, 24'h000000};
        logic        to [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            a_s = ta[i];
            b_s = tb[i];
            #1;
            n_chk++;
            if (r_s !== tr[i] || o_s !== to[i]) begin
                n_err++;
                $display("FAIL signed_dir%0d: got res=%h ovf=%b, expected res=%h ovf=%b",
                         i, r_s, o_s, tr[i], to[i]);
            end
        end
    endtask

    task automatic test_comb_random();
        logic [13:0] corner [5] = '{14'd0, 14'd1, 14'd8191, 14'd8192, 14'd16383};
        logic [31:0] m_res;
        logic        m_ovf;
        for (int i = 0; i < 65; i++) begin
            if (i < 25) begin
                a_u = corner[i / 5];
                b_u = corner[i % 5];
            end else begin
                a_u = 14'($urandom_range(0, 16383));
                b_u = 14'($urandom_range(0, 16383));
            end
            a_s = a_u;
            b_s = b_u;
            #1;
            model(int'(a_u), int'(b_u), 1'b0, 24, m_res, m_ovf);
            n_chk++;
            if (r_u !== m_res[23:0] || o_u !== m_ovf) begin
                n_err++;
                $display("FAIL comb_unsigned a=%h b=%h: got res=%h ovf=%b, expected res=%h ovf=%b",
                         a_u, b_u, r_u, o_u, m_res[23:0], m_ovf);
            end
            model(int'(a_s), int'(b_s), 1'b1, 24, m_res, m_ovf);
            n_chk++;
            if (r_s !== m_res[23:0] || o_s !== m_ovf) begin
                n_err++;
                $display("FAIL comb_signed a=%h b=%h: got res=%h ovf=%b, expected res=%h ovf=%b",
                         a_s, b_s, r_s, o_s, m_res[23:0], m_ovf);
            end
            model(int'(a_s), int'(b_s), 1'b1, 32, m_res, m_ovf);
            n_chk++;
            if (r_w !== m_res || o_w !== m_ovf) begin
                n_err++;
                $display("FAIL comb_wide a=%h b=%h: got res=%h ovf=%b, expected res=%h ovf=%b",
                         a_s, b_s, r_w, o_w, m_res, m_ovf);
            end
        end
    endtask

    task automatic test_latency();
        step(14'd3, 14'd5, 1'b1);
        n_chk++;
        if (r_l !== 24'd0) begin
            n_err++;
            $display("FAIL latency_first_edge: got res=%h, expected res=000000", r_l);
        end
        step(14'd7, 14'd9, 1'b1);
        n_chk++;
        if (r_l !== 24'd15) begin
            n_err++;
            $display("FAIL latency_second_edge: got res=%h, expected res=00000f", r_l);
        end
        step(14'd0, 14'd0, 1'b1);
        n_chk++;
        if (r_l !== 24'd63) begin
            n_err++;
            $display("FAIL latency_third_edge: got res=%h, expected res=00003f", r_l);
        end
    endtask

    task automatic test_ena_hold();
        step(14'd100, 14'd200, 1'b1);
        step(14'd16383, 14'd16383, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)), 1'b0);
            n_chk++;
            if (r_l !== 24'h004E20 || o_l !== 1'b0) begin
                n_err++;
                $display("FAIL ena_hold%0d: got res=%h ovf=%b, expected res=004e20 ovf=0",
                         i, r_l, o_l);
            end
        end
        step(14'd1, 14'd1, 1'b1);
        n_chk++;
        if (r_l !== 24'hFF8001 || o_l !== 1'b1) begin
            n_err++;
            $display("FAIL ena_resume: got res=%h ovf=%b, expected res=ff8001 ovf=1", r_l, o_l);
        end
        step(14'd2, 14'd2, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            step(14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)),
                 ($urandom_range(0, 3) != 0));
        end
    endtask

    task automatic test_reset_midflight();
        step(14'd16383, 14'd4096, 1'b1);
        step(14'd3, 14'd5, 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        n_chk++;
        if (r_l !== 24'd0 || o_l !== 1'b0) begin
            n_err++;
            $display("FAIL reset_midflight: got res=%h ovf=%b, expected res=000000 ovf=0",
                     r_l, o_l);
        end
        exp_q = '{25'd0, 25'd0};
        @(negedge clk);
        reset_n = 1'b1;
        step(14'd11, 14'd13, 1'b1);
        n_chk++;
        if (r_l !== 24'd0) begin
            n_err++;
            $display("FAIL reset_release_first: got res=%h, expected res=000000", r_l);
        end
        step(14'd0, 14'd0, 1'b1);
        n_chk++;
        if (r_l !== 24'd143) begin
            n_err++;
            $display("FAIL reset_release_second: got res=%h, expected res=00008f", r_l);
        end
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        reset_n = 1'b1;
        ena     = 1'b0;
        a_u = '0; b_u = '0; a_s = '0; b_s = '0; a_l = '0; b_l = '0;
        test_reset();
        test_unsigned_directed();
        test_signed_directed();
        test_comb_random();
        test_latency();
        test_ena_hold();
        test_back_to_back();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_mult_14x14
